net_rx_dispatch: RTL and testbench
==================================

NET_RX_DISPATCH -- requirements
Module: net_rx_dispatch

Interface
REQ-001 Parameter DATA_W, default 512: packet word data width.
REQ-002 Parameter DEV_W, default 8: device-ID field width.
REQ-003 Parameter USER_W, default 8: user-ID field width; address width ADDR_W = DEV_W+USER_W.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 my_device_id  in  DEV_W  local device ID; static while traffic is in flight.
REQ-007 net_size  in  DEV_W  number of devices in the network.
REQ-008 in_valid / in_first / in_last  in  1 each  word valid, first word of packet, last word of packet.
REQ-009 in_data  in  DATA_W  word payload.
REQ-010 in_src / in_dest / in_meta  in  ADDR_W each  packet header; in_dest = {device ID [ADDR_W-1:USER_W], user ID [USER_W-1:0]}.
REQ-011 in_ready  out  1  word accepted when in_valid & in_ready.
REQ-012 loc_valid, loc_first, loc_last, loc_data, loc_src, loc_dest, loc_meta  out  as inputs  local-delivery port.
REQ-013 loc_ready  in  1  local port backpressure.
REQ-014 fwd_valid, fwd_first, fwd_last, fwd_data, fwd_src, fwd_dest, fwd_meta  out  as inputs  transit (forward) port.
REQ-015 fwd_ready  in  1  forward port backpressure.
REQ-016 cnt_local / cnt_fwd / cnt_drop  out  16 each  packets delivered / forwarded / dropped.
REQ-017 err_midpkt_first  out  1  sticky protocol-error flag.

Function
REQ-018 FSM states: IDLE, LOCAL, FWD, DROP.
REQ-019 IDLE: on accepted word with in_first, decode D = in_dest[ADDR_W-1:USER_W]; D==my_device_id -> LOCAL; else D<net_size -> FWD; else DROP.
REQ-020 The decision SHALL apply to the first word itself; a word with in_first & in_last is a complete one-word packet, and the FSM stays in IDLE.
REQ-021 IDLE: accepted word without in_first SHALL be discarded silently; no counter change.
REQ-022 LOCAL/FWD/DROP: every accepted word SHALL follow the locked route; on accepted in_last the FSM returns to IDLE next cycle.
REQ-023 Each output port SHALL have a one-entry output register; latency from input accept to port valid is 1 cycle.
REQ-024 Output register payload SHALL hold stable while valid & ~ready.
REQ-025 in_ready (combinational) SHALL be: IDLE -> 1 if the decoded target register is empty or draining this cycle, 1 for DROP; LOCAL/FWD -> locked register empty or draining; DROP -> 1.
REQ-026 A draining register SHALL be reloaded in the same cycle (full throughput, 1 word/cycle/port).
REQ-027 Words on the DROP route SHALL never appear on either port.
REQ-028 Header fields SHALL be captured from the first word and repeated on every output word of that packet; later-word in_src/in_dest/in_meta are ignored.
REQ-029 cnt_local/cnt_fwd SHALL increment when a last word leaves the port (valid & ready & last); cnt_drop increments when a dropped packet's last word is accepted.
REQ-030 Counters SHALL saturate at 16'hFFFF.
REQ-031 in_first on a non-first word in LOCAL/FWD/DROP SHALL set err_midpkt_first; the word is treated as a continuation word; route unchanged.
REQ-032 Ports are independent: a stalled fwd port SHALL NOT block a subsequent local packet once the forward packet's last word has been accepted into its register.

Reset
REQ-033 On rst_n=0: FSM=IDLE, loc_valid=fwd_valid=0, all other outputs 0, counters 0, err_midpkt_first=0; in_ready follows REQ-025 with empty registers.
REQ-034 Reset mid-packet SHALL discard the held words and the partial packet; the first post-reset word without in_first is discarded per REQ-021.

Verification
REQ-035 my_device_id=3, net_size=8, 4-word packet with dest device 3, both ready=1 -> 4 words on loc port, 1 cycle later each, loc_first only on word 0, cnt_local=1.
REQ-036 Dest device 5, fwd_ready held 0 for 5 cycles -> in_ready=0 after 1 word, fwd_data stable, no loss; cnt_fwd=1 after the last word drains.
REQ-037 Dest device 9 with net_size=8 -> 3-word packet is accepted at 1 word/cycle, no port activity, cnt_drop=1.
REQ-038 Back-to-back one-word packets (first&last) alternating local/fwd, both ready -> 1 word/cycle accepted, cnt_local and cnt_fwd each count every packet.
REQ-039 in_first asserted on word 2 of a local packet -> err_midpkt_first=1, word delivered on loc port, cnt_local=1 at the packet end.
REQ-040 rst_n pulsed while a fwd packet is half-delivered -> all outputs 0 next cycle; the next packet with in_first routes correctly.

Source files
------------

// File: rtl/net_rx_dispatch.sv
// Receive-side packet dispatcher: routes each packet to the local port, the forward port,
// or discards it, based on the destination device ID in its first word.
module net_rx_dispatch #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEV_W  = 8,
  parameter int unsigned USER_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DEV_W-1:0]          my_device_id,
  input  logic [DEV_W-1:0]          net_size,
  input  logic                      in_valid,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [DEV_W+USER_W-1:0]   in_src,
  input  logic [DEV_W+USER_W-1:0]   in_dest,
  input  logic [DEV_W+USER_W-1:0]   in_meta,
  output logic                      in_ready,
  output logic                      loc_valid,
  output logic                      loc_first,
  output logic                      loc_last,
  output logic [DATA_W-1:0]         loc_data,
  output logic [DEV_W+USER_W-1:0]   loc_src,
  output logic [DEV_W+USER_W-1:0]   loc_dest,
  output logic [DEV_W+USER_W-1:0]   loc_meta,
  input  logic                      loc_ready,
  output logic                      fwd_valid,
  output logic                      fwd_first,
  output logic                      fwd_last,
  output logic [DATA_W-1:0]         fwd_data,
  output logic [DEV_W+USER_W-1:0]   fwd_src,
  output logic [DEV_W+USER_W-1:0]   fwd_dest,
  output logic [DEV_W+USER_W-1:0]   fwd_meta,
  input  logic                      fwd_ready,
  output logic [15:0]               cnt_local,
  output logic [15:0]               cnt_fwd,
  output logic [15:0]               cnt_drop,
  output logic                      err_midpkt_first
);

  localparam int unsigned ADDR_W = DEV_W + USER_W;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_LOCAL, ST_FWD, ST_DROP} state_e;

  state_e              state_q;
  state_e              first_route;
  state_e              route;
  logic [DEV_W-1:0]    dec_dev;
  logic                loc_free;
  logic                fwd_free;
  logic                accept;
  logic                in_idle;
  logic                push_loc;
  logic                push_fwd;
  logic                loc_done;
  logic                fwd_done;
  logic                drop_done;

  logic [ADDR_W-1:0]   hdr_src_q, hdr_dest_q, hdr_meta_q;
  logic [ADDR_W-1:0]   hdr_src_d, hdr_dest_d, hdr_meta_d;

  logic                loc_valid_q, loc_first_q, loc_last_q;
  logic [DATA_W-1:0]   loc_data_q;
  logic [ADDR_W-1:0]   loc_src_q, loc_dest_q, loc_meta_q;
  logic                fwd_valid_q, fwd_first_q, fwd_last_q;
  logic [DATA_W-1:0]   fwd_data_q;
  logic [ADDR_W-1:0]   fwd_src_q, fwd_dest_q, fwd_meta_q;
  logic [CNT_W-1:0]    cnt_local_q, cnt_fwd_q, cnt_drop_q;
  logic                err_q;

  // Route decode: first word in IDLE decides, later words follow the locked state.
  always_comb begin
    dec_dev     = in_dest[ADDR_W-1:USER_W];
    first_route = ST_DROP;
    if (dec_dev == my_device_id) begin
      first_route = ST_LOCAL;
    end else if (dec_dev < net_size) begin
      first_route = ST_FWD;
    end
    in_idle = (state_q == ST_IDLE);
    route   = state_q;
    if (in_idle) begin
      route = in_first ? first_route : ST_IDLE;
    end
  end

  assign loc_free = ~loc_valid_q | loc_ready;
  assign fwd_free = ~fwd_valid_q | fwd_ready;

  always_comb begin
    in_ready = 1'b1;
    if (route == ST_LOCAL) begin
      in_ready = loc_free;
    end else if (route == ST_FWD) begin
      in_ready = fwd_free;
    end
  end

  assign accept    = in_valid & in_ready;
  assign push_loc  = accept & (route == ST_LOCAL);
  assign push_fwd  = accept & (route == ST_FWD);
  assign loc_done  = loc_valid_q & loc_ready & loc_last_q;
  assign fwd_done  = fwd_valid_q & fwd_ready & fwd_last_q;
  assign drop_done = accept & (route == ST_DROP) & in_last;

  // Header comes straight from the bus on the first word, from the capture regs afterwards.
  assign hdr_src_d  = in_idle ? in_src  : hdr_src_q;
  assign hdr_dest_d = in_idle ? in_dest : hdr_dest_q;
  assign hdr_meta_d = in_idle ? in_meta : hdr_meta_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hdr_src_q   <= '0;
      hdr_dest_q  <= '0;
      hdr_meta_q  <= '0;
      loc_valid_q <= 1'b0;
      loc_first_q <= 1'b0;
      loc_last_q  <= 1'b0;
      loc_data_q  <= '0;
      loc_src_q   <= '0;
      loc_dest_q  <= '0;
      loc_meta_q  <= '0;
      fwd_valid_q <= 1'b0;
      fwd_first_q <= 1'b0;
      fwd_last_q  <= 1'b0;
      fwd_data_q  <= '0;
      fwd_src_q   <= '0;
      fwd_dest_q  <= '0;
      fwd_meta_q  <= '0;
      cnt_local_q <= '0;
      cnt_fwd_q   <= '0;
      cnt_drop_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        if (in_idle) begin
          if (in_first && !in_last) begin
            state_q <= first_route;
          end
        end else if (in_last) begin
          state_q <= ST_IDLE;
        end
      end

      if (accept && in_idle && in_first) begin
        hdr_src_q  <= in_src;
        hdr_dest_q <= in_dest;
        hdr_meta_q <= in_meta;
      end

      if (accept && !in_idle && in_first) begin
        err_q <= 1'b1;
      end

      // One-entry local register; reload while draining keeps 1 word/cycle.
      if (push_loc) begin
        loc_valid_q <= 1'b1;
        loc_first_q <= in_idle;
        loc_last_q  <= in_last;
        loc_data_q  <= in_data;
        loc_src_q   <= hdr_src_d;
        loc_dest_q  <= hdr_dest_d;
        loc_meta_q  <= hdr_meta_d;
      end else if (loc_ready) begin
        loc_valid_q <= 1'b0;
      end

      if (push_fwd) begin
        fwd_valid_q <= 1'b1;
        fwd_first_q <= in_idle;
        fwd_last_q  <= in_last;
        fwd_data_q  <= in_data;
        fwd_src_q   <= hdr_src_d;
        fwd_dest_q  <= hdr_dest_d;
        fwd_meta_q  <= hdr_meta_d;
      end else if (fwd_ready) begin
        fwd_valid_q <= 1'b0;
      end

      // Saturating packet counters.
      if (loc_done && (cnt_local_q != '1)) begin
        cnt_local_q <= cnt_local_q + CNT_W'(1);
      end
      if (fwd_done && (cnt_fwd_q != '1)) begin
        cnt_fwd_q <= cnt_fwd_q + CNT_W'(1);
      end
      if (drop_done && (cnt_drop_q != '1)) begin
        cnt_drop_q <= cnt_drop_q + CNT_W'(1);
      end
    end
  end

  assign loc_valid        = loc_valid_q;
  assign loc_first        = loc_first_q;
  assign loc_last         = loc_last_q;
  assign loc_data         = loc_data_q;
  assign loc_src          = loc_src_q;
  assign loc_dest         = loc_dest_q;
  assign loc_meta         = loc_meta_q;
  assign fwd_valid        = fwd_valid_q;
  assign fwd_first        = fwd_first_q;
  assign fwd_last         = fwd_last_q;
  assign fwd_data         = fwd_data_q;
  assign fwd_src          = fwd_src_q;
  assign fwd_dest         = fwd_dest_q;
  assign fwd_meta         = fwd_meta_q;
  assign cnt_local        = cnt_local_q;
  assign cnt_fwd          = cnt_fwd_q;
  assign cnt_drop         = cnt_drop_q;
  assign err_midpkt_first = err_q;

endmodule

// File: tb/tb_net_rx_dispatch.sv
// Directed bench for net_rx_dispatch: local, forward, drop, back-to-back,
// mid-packet first flag and reset mid-packet, with hand-computed expectations.
module tb_net_rx_dispatch;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEV_W  = 8;
  localparam int unsigned USER_W = 8;
  localparam int unsigned ADDR_W = DEV_W + USER_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DEV_W-1:0]  my_device_id, net_size;
  logic              in_valid, in_first, in_last, in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_src, in_dest, in_meta;
  logic              loc_valid, loc_first, loc_last, loc_ready;
  logic [DATA_W-1:0] loc_data;
  logic [ADDR_W-1:0] loc_src, loc_dest, loc_meta;
  logic              fwd_valid, fwd_first, fwd_last, fwd_ready;
  logic [DATA_W-1:0] fwd_data;
  logic [ADDR_W-1:0] fwd_src, fwd_dest, fwd_meta;
  logic [15:0]       cnt_local, cnt_fwd, cnt_drop;
  logic              err_midpkt_first;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  net_rx_dispatch #(.DATA_W(DATA_W), .DEV_W(DEV_W), .USER_W(USER_W)) dut (
    .clk(clk), .rst_n(rst_n), .my_device_id(my_device_id), .net_size(net_size),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .in_data(in_data),
    .in_src(in_src), .in_dest(in_dest), .in_meta(in_meta), .in_ready(in_ready),
    .loc_valid(loc_valid), .loc_first(loc_first), .loc_last(loc_last), .loc_data(loc_data),
    .loc_src(loc_src), .loc_dest(loc_dest), .loc_meta(loc_meta), .loc_ready(loc_ready),
    .fwd_valid(fwd_valid), .fwd_first(fwd_first), .fwd_last(fwd_last), .fwd_data(fwd_data),
    .fwd_src(fwd_src), .fwd_dest(fwd_dest), .fwd_meta(fwd_meta), .fwd_ready(fwd_ready),
    .cnt_local(cnt_local), .cnt_fwd(cnt_fwd), .cnt_drop(cnt_drop),
    .err_midpkt_first(err_midpkt_first)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Later words carry junk header fields that must not reach the ports.
  task automatic drive(input bit v, input bit f, input bit l, input logic [31:0] d,
                       input logic [15:0] dst);
    in_valid = v;
    in_first = f;
    in_last  = l;
    in_data  = d;
    in_dest  = dst;
    in_src   = f ? 16'h0102 : 16'hDEAD;
    in_meta  = f ? 16'h0A0B : 16'hBEEF;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; my_device_id = 8'd3; net_size = 8'd8;
    loc_ready = 1'b1; fwd_ready = 1'b1;
    drive(0, 0, 0, 0, 16'h0);
    step(); step();
    chk("rst_loc_valid", 64'(loc_valid), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_counters", {16'h0, cnt_local, cnt_fwd, cnt_drop}, 64'd0);
    chk("rst_err", 64'(err_midpkt_first), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    step();

    // 4-word local packet to device 3.
    for (int k = 0; k < 4; k++) begin
      drive(1, k == 0, k == 3, 32'h100 + 32'(k), (k == 0) ? 16'h0307 : 16'hFFFF);
      chk("loc4_in_ready", 64'(in_ready), 64'd1);
      step();
      chk("loc4_valid", 64'(loc_valid), 64'd1);
      chk("loc4_data", 64'(loc_data), 64'h100 + 64'(k));
      chk("loc4_flags", {62'd0, loc_first, loc_last}, {62'd0, k == 0, k == 3});
      chk("loc4_hdr", {16'h0, loc_src, loc_dest, loc_meta}, 64'h0102_0307_0A0B);
      chk("loc4_fwd_quiet", 64'(fwd_valid), 64'd0);
    end
    drive(0, 0, 0, 0, 16'h0);
    step();
    chk("loc4_drained", 64'(loc_valid), 64'd0);
    chk("loc4_cnt_local", 64'(cnt_local), 64'd1);

    // 3-word forward packet to device 5 with a 5-cycle stall.
    fwd_ready = 1'b0;
    drive(1, 1, 0, 32'h200, 16'h0501);
    chk("fwd_w0_ready", 64'(in_ready), 64'd1);
    step();
    chk("fwd_w0_data", 64'(fwd_data), 64'h200);
    drive(1, 0, 0, 32'h201, 16'hFFFF);
    chk("fwd_stall_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fwd_stall_valid", 64'(fwd_valid), 64'd1);
      chk("fwd_stall_data", 64'(fwd_data), 64'h200);
      chk("fwd_stall_dest", 64'(fwd_dest), 64'h0501);
      chk("fwd_stall_ready_hold", 64'(in_ready), 64'd0);
    end
    fwd_ready = 1'b1;
    #1;
    chk("fwd_release_ready", 64'(in_ready), 64'd1);
    step();
    chk("fwd_w1_data", 64'(fwd_data), 64'h201);
    chk("fwd_w1_first", 64'(fwd_first), 64'd0);
    drive(1, 0, 1, 32'h202, 16'hFFFF);
    step();
    chk("fwd_w2_data", 64'(fwd_data), 64'h202);
    chk("fwd_w2_last", 64'(fwd_last), 64'd1);
    chk("fwd_cnt_before_drain", 64'(cnt_fwd), 64'd0);
    drive(0, 0, 0, 0, 16'h0);
    step();
    chk("fwd_cnt", 64'(cnt_fwd), 64'd1);
    chk("fwd_drained", 64'(fwd_valid), 64'd0);

    // 3-word packet to device 9 is out of range and dropped.
    for (int k = 0; k < 3; k++) begin
      drive(1, k == 0, k == 2, 32'h300 + 32'(k), (k == 0) ? 16'h0900 : 16'h0300);
      chk("drop_in_ready", 64'(in_ready), 64'd1);
      step();
      chk("drop_no_port", {62'd0, loc_valid, fwd_valid}, 64'd0);
    end
    chk("drop_cnt", 64'(cnt_drop), 64'd1);
    drive(0, 0, 0, 0, 16'h0);
    step();

    // Back-to-back one-word packets alternating local/forward.
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 1, 32'h400 + 32'(k), (k % 2 == 0) ? 16'h0300 : 16'h0100);
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      step();
      if (k % 2 == 0) begin
        chk("b2b_loc_data", 64'(loc_data), 64'h400 + 64'(k));
        chk("b2b_loc_valid", 64'(loc_valid), 64'd1);
      end else begin
        chk("b2b_fwd_data", 64'(fwd_data), 64'h400 + 64'(k));
        chk("b2b_fwd_valid", 64'(fwd_valid), 64'd1);
      end
    end
    drive(0, 0, 0, 0, 16'h0);
    step();
    chk("b2b_cnt_local", 64'(cnt_local), 64'd4);
    chk("b2b_cnt_fwd", 64'(cnt_fwd), 64'd4);

    // Local packet with a stray first flag on its second word (junk dest device 5).
    chk("err_before", 64'(err_midpkt_first), 64'd0);
    drive(1, 1, 0, 32'h500, 16'h0302);
    step();
    drive(1, 1, 0, 32'h501, 16'h0500);
    step();
    chk("err_set", 64'(err_midpkt_first), 64'd1);
    chk("err_word_loc", 64'(loc_data), 64'h501);
    chk("err_word_not_first", 64'(loc_first), 64'd0);
    chk("err_word_hdr", 64'(loc_dest), 64'h0302);
    chk("err_no_fwd", 64'(fwd_valid), 64'd0);
    drive(1, 0, 1, 32'h502, 16'hFFFF);
    step();
    drive(0, 0, 0, 0, 16'h0);
    step();
    chk("err_cnt_local", 64'(cnt_local), 64'd5);

    // Reset while a forward packet is half-delivered.
    drive(1, 1, 0, 32'h600, 16'h0500);
    step();
    drive(1, 0, 0, 32'h601, 16'hFFFF);
    step();
    drive(0, 0, 0, 0, 16'h0);
    rst_n = 1'b0;
    step();
    chk("midrst_outputs", {47'd0, loc_valid, fwd_valid, fwd_data[15:0]}, 64'd0);
    chk("midrst_counters", {15'd0, err_midpkt_first, cnt_local, cnt_fwd, cnt_drop}, 64'd0);
    rst_n = 1'b1;
    drive(1, 0, 1, 32'h602, 16'h0500);
    chk("postrst_orphan_ready", 64'(in_ready), 64'd1);
    step();
    chk("postrst_orphan_quiet", {62'd0, loc_valid, fwd_valid}, 64'd0);
    drive(1, 1, 1, 32'h700, 16'h0304);
    step();
    chk("postrst_loc_data", 64'(loc_data), 64'h700);
    chk("postrst_loc_valid", 64'(loc_valid), 64'd1);
    drive(1, 1, 0, 32'h710, 16'h0201);
    step();
    chk("postrst_fwd_data", 64'(fwd_data), 64'h710);
    drive(1, 0, 1, 32'h711, 16'hFFFF);
    step();
    chk("postrst_fwd_dest", 64'(fwd_dest), 64'h0201);
    drive(0, 0, 0, 0, 16'h0);
    step();
    chk("postrst_counts", {32'd0, cnt_local, cnt_fwd}, {32'd0, 16'd1, 16'd1});
    chk("postrst_cnt_drop", 64'(cnt_drop), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
